// File: rtl/fetch_queue_if.sv
// Bundle of the instruction-memory, redirect and decode handshake signals of fetch_queue.
// Decode handshake: dec_valid/dec_instr/dec_pc hold steady until a cycle with dec_valid & dec_ready.
interface fetch_queue_if #(
    parameter int QDEPTH = 4
);
    logic                          imem_req;
    logic [31:0]                   imem_addr;
    logic [31:0]                   imem_rdata;
    logic                          redirect_valid;
    logic [31:0]                   redirect_pc;
    logic                          dec_valid;
    logic                          dec_ready;
    logic [31:0]                   dec_instr;
    logic [31:0]                   dec_pc;
    logic [$clog2(QDEPTH+1)-1:0]   fq_level;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fq_level,
        input  imem_rdata, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, fq_level,
        output imem_rdata, redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// PC generator plus prefetch queue in front of decode; fetches sequentially from a
// 1-cycle-latency instruction memory and flushes everything on a redirect.
module fetch_queue #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master fq
);
    localparam int CW = $clog2(QDEPTH + 1);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(QDEPTH);

    logic [31:0]   pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   instr_mem [QDEPTH];
    logic [31:0]   pc_mem    [QDEPTH];

    logic [CW:0]   credit_used;
    logic          not_empty;
    logic          present;
    logic          issue;
    logic          push;
    logic          pop;

    // The in-flight fetch holds a queue slot, so a response can never find the queue full.
    always_comb begin
        not_empty   = (count != '0);
        credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
        issue       = !rst && !fq.redirect_valid && (credit_used < DEPTH_C);
        push        = inflight && !rst && !fq.redirect_valid;
        present     = not_empty && !rst && !fq.redirect_valid;
        pop         = present && fq.dec_ready;
    end

    assign fq.imem_req  = issue;
    assign fq.imem_addr = pc;
    assign fq.dec_valid = present;
    assign fq.dec_instr = (not_empty && !rst) ? instr_mem[rd_ptr] : 32'h0;
    assign fq.dec_pc    = (not_empty && !rst) ? pc_mem[rd_ptr]    : 32'h0;
    assign fq.fq_level  = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (fq.redirect_valid) begin
            pc       <= {fq.redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= fq.imem_rdata;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model compared every cycle, plus directed
// literal expectations for reset, stall, redirect, PC wrap and mid-stream reset.
module tb_fetch_queue;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_PAT  = 32'hA5A5_0000;

  logic clk;
  logic rst;
  logic [31:0] last_addr;
  int checks;
  int errors;
  int n_req;

  fetch_queue_if #(.QDEPTH(QDEPTH)) fq ();

  fetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: returns addr ^ XOR_PAT one cycle after the request
  always @(posedge clk) last_addr <= fq.imem_addr;
  assign fq.imem_rdata = last_addr ^ XOR_PAT;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected queue of PCs held in the prefetch queue
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_inf_pc;
  logic        m_inf;
  logic        model_ok;
  logic        e_req;
  logic        e_valid;

  initial begin
    model_ok = 1'b0;
    m_inf    = 1'b0;
    m_pc     = RESET_PC;
    m_inf_pc = 32'h0;
  end

  always @(negedge clk) begin
    e_req   = !rst && !fq.redirect_valid && ((exp_q.size() + int'(m_inf)) < QDEPTH);
    e_valid = (exp_q.size() != 0) && !fq.redirect_valid && !rst;
    if (model_ok) begin
      check("m_imem_req", {31'b0, fq.imem_req}, {31'b0, e_req});
      check("m_imem_addr", fq.imem_addr, m_pc);
      check("m_dec_valid", {31'b0, fq.dec_valid}, {31'b0, e_valid});
      check("m_fq_level", 32'(fq.fq_level), 32'(exp_q.size()));
      if (exp_q.size() == 0) begin
        check("m_dec_pc_empty", fq.dec_pc, 32'h0);
        check("m_dec_instr_empty", fq.dec_instr, 32'h0);
      end else if (!rst) begin
        check("m_dec_pc", fq.dec_pc, exp_q[0]);
        check("m_dec_instr", fq.dec_instr, exp_q[0] ^ XOR_PAT);
      end
    end
    // advance the model to the state after the coming posedge
    if (rst) begin
      exp_q.delete();
      m_pc     = RESET_PC;
      m_inf    = 1'b0;
      model_ok = 1'b1;
    end else if (fq.redirect_valid) begin
      exp_q.delete();
      m_pc  = {fq.redirect_pc[31:2], 2'b00};
      m_inf = 1'b0;
    end else begin
      if (e_valid && fq.dec_ready) void'(exp_q.pop_front());
      if (m_inf) begin
        checks++;
        if (exp_q.size() >= QDEPTH) begin
          errors++;
          $display("FAIL overflow actual level %0d expected below %0d", exp_q.size(), QDEPTH);
        end
        exp_q.push_back(m_inf_pc);
      end
      m_inf = e_req;
      if (e_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc = 32'h0;
    fq.dec_ready = 1'b1;

    // 1: sequential fetch with decode always ready
    step(); step();
    rst = 1'b0; settle();
    check("t1_c0_req", {31'b0, fq.imem_req}, 32'h1);
    check("t1_c0_addr", fq.imem_addr, 32'h0);
    check("t1_c0_valid", {31'b0, fq.dec_valid}, 32'h0);
    step(); settle();
    check("t1_c1_addr", fq.imem_addr, 32'h4);
    check("t1_c1_valid", {31'b0, fq.dec_valid}, 32'h0);
    step(); settle();
    check("t1_c2_valid", {31'b0, fq.dec_valid}, 32'h1);
    check("t1_c2_pc", fq.dec_pc, 32'h0);
    check("t1_c2_instr", fq.dec_instr, 32'hA5A5_0000);
    step(); settle();
    check("t1_c3_pc", fq.dec_pc, 32'h4);
    step(); settle();
    check("t1_c4_pc", fq.dec_pc, 32'h8);
    check("t1_c4_level", 32'(fq.fq_level), 32'd1);

    // 2: decode stalled from reset, queue fills to credit limit
    rst = 1'b1; fq.dec_ready = 1'b0;
    step();
    rst = 1'b0;
    n_req = 0;
    for (int i = 0; i < 8; i++) begin
      settle();
      n_req += int'(fq.imem_req);
      step();
    end
    settle();
    check("t2_nreq", 32'(n_req), 32'd4);
    check("t2_level", 32'(fq.fq_level), 32'd4);
    check("t2_req_off", {31'b0, fq.imem_req}, 32'h0);
    check("t2_addr_hold", fq.imem_addr, 32'h10);
    fq.dec_ready = 1'b1; settle();
    check("t2_pop_pc", fq.dec_pc, 32'h0);
    step();
    fq.dec_ready = 1'b0; settle();
    check("t2_refill_req", {31'b0, fq.imem_req}, 32'h1);
    check("t2_refill_addr", fq.imem_addr, 32'h10);
    check("t2_refill_level", 32'(fq.fq_level), 32'd3);

    // 3: redirect with 3 queued and 1 in flight
    step();
    fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h0000_0103; settle();
    check("t3_T_level", 32'(fq.fq_level), 32'd3);
    check("t3_T_valid", {31'b0, fq.dec_valid}, 32'h0);
    check("t3_T_req", {31'b0, fq.imem_req}, 32'h0);
    step();
    fq.redirect_valid = 1'b0; settle();
    check("t3_T1_level", 32'(fq.fq_level), 32'd0);
    check("t3_T1_addr", fq.imem_addr, 32'h100);
    check("t3_T1_req", {31'b0, fq.imem_req}, 32'h1);
    step(); settle();
    check("t3_T2_valid", {31'b0, fq.dec_valid}, 32'h0);
    step(); settle();
    check("t3_T3_valid", {31'b0, fq.dec_valid}, 32'h1);
    check("t3_T3_pc", fq.dec_pc, 32'h100);
    check("t3_T3_instr", fq.dec_instr, 32'hA5A5_0100);

    // 4: PC wrap at the top of the address space
    step();
    fq.dec_ready = 1'b1;
    fq.redirect_valid = 1'b1; fq.redirect_pc = 32'hFFFF_FFF8;
    step();
    fq.redirect_valid = 1'b0; settle();
    check("t4_addr0", fq.imem_addr, 32'hFFFF_FFF8);
    step(); settle();
    check("t4_addr1", fq.imem_addr, 32'hFFFF_FFFC);
    step(); settle();
    check("t4_addr2", fq.imem_addr, 32'h0000_0000);
    check("t4_pc0", fq.dec_pc, 32'hFFFF_FFF8);
    step(); settle();
    check("t4_pc1", fq.dec_pc, 32'hFFFF_FFFC);
    step(); settle();
    check("t4_pc2", fq.dec_pc, 32'h0000_0000);
    check("t4_instr2", fq.dec_instr, 32'hA5A5_0000);

    // 5: reset mid-stream with credit exhausted and a fetch in flight
    fq.dec_ready = 1'b0;
    fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h200;
    step();
    fq.redirect_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1; settle();
    check("t5_rst_level", 32'(fq.fq_level), 32'd3);
    check("t5_rst_req", {31'b0, fq.imem_req}, 32'h0);
    check("t5_rst_valid", {31'b0, fq.dec_valid}, 32'h0);
    step();
    rst = 1'b0; settle();
    check("t5_post_level", 32'(fq.fq_level), 32'd0);
    check("t5_post_valid", {31'b0, fq.dec_valid}, 32'h0);
    check("t5_post_addr", fq.imem_addr, RESET_PC);
    step(); settle();
    check("t5_no_stale_push", 32'(fq.fq_level), 32'd0);
    step(); settle();
    check("t5_first_level", 32'(fq.fq_level), 32'd1);
    check("t5_first_pc", fq.dec_pc, RESET_PC);

    // 6: random decode back-pressure, redirects and occasional reset
    for (int i = 0; i < 10000; i++) begin
      step();
      fq.dec_ready      = ($urandom_range(0, 3) != 0);
      fq.redirect_valid = ($urandom_range(0, 31) == 0);
      fq.redirect_pc    = $urandom;
      rst               = ($urandom_range(0, 499) == 0);
    end
    step();
    rst = 1'b0; fq.redirect_valid = 1'b0; fq.dec_ready = 1'b1;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
